// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_chain
// Description : Elastic valid/ready register chain with bubble collapsing,
//               synchronous flush and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] w_adv;
    logic             w_room0;
    logic             w_accept;

    // Walk from the output side: a stage advances when the stage ahead of it
    // is empty or is itself advancing this cycle.
    always_comb begin : p_adv
        logic room;
        room  = out_ready;
        w_adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_adv[i] = r_valid[i] & room;
            room     = ~r_valid[i] | w_adv[i];
        end
        w_room0 = room;
    end

    assign in_ready  = ~flush & w_room0;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            // Payload registers are left untouched; only validity is squashed.
            r_valid <= '0;
        end else begin
            if (w_accept) begin
                r_valid[0] <= 1'b1;
                r_data[0]  <= in_data;
            end else if (w_adv[0]) begin
                r_valid[0] <= 1'b0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_adv[i-1]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= r_data[i-1];
                end else if (w_adv[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin : p_occ
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + CNT_W'(r_valid[i]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_chain
// Description : Self-checking bench for pipe_stage_chain (DEPTH 3 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [38:0] in_data;
    logic        out_ready;
    logic        flush;

    logic        ir3, ov3, ir4, ov4;
    logic [38:0] od3, od4;
    logic [1:0]  oc3;
    logic [2:0]  oc4;

    pipe_stage_chain #(.WIDTH(39), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(out_ready),
        .flush(flush), .occupancy(oc3)
    );

    pipe_stage_chain #(.WIDTH(39), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir4), .out_valid(ov4), .out_data(od4), .out_ready(out_ready),
        .flush(flush), .occupancy(oc4)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mv [2][4];
    logic [38:0] md [2][4];
    int          dep [2] = '{3, 4};
    logic [38:0] sb [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [38:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[38:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                mv[k][i] = 1'b0;
                md[k][i] = '0;
            end
    endtask

    // Chain as a row of slots: the head item leaves if taken, then every item
    // steps forward into a free slot, then a new item may enter slot 0.
    task automatic sweep(input int k, input bit commit, output bit rdy);
        bit          v [4];
        logic [38:0] d [4];
        int          dd;
        dd = dep[k];
        for (int i = 0; i < 4; i++) begin
            v[i] = mv[k][i];
            d[i] = md[k][i];
        end
        rdy = 1'b0;
        if (flush) begin
            for (int i = 0; i < 4; i++) v[i] = 1'b0;
        end else begin
            for (int i = dd - 1; i >= 0; i--) begin
                if (v[i]) begin
                    if (i == dd - 1) begin
                        if (out_ready) v[i] = 1'b0;
                    end else if (!v[i+1]) begin
                        v[i+1] = 1'b1;
                        d[i+1] = d[i];
                        v[i]   = 1'b0;
                    end
                end
            end
            rdy = !v[0];
            if (in_valid && rdy) begin
                v[0] = 1'b1;
                d[0] = in_data;
            end
        end
        if (commit)
            for (int i = 0; i < 4; i++) begin
                mv[k][i] = v[i];
                md[k][i] = d[i];
            end
    endtask

    task automatic check_model(input int k);
        bit rdy;
        int cnt;
        int dd;
        dd  = dep[k];
        cnt = 0;
        sweep(k, 1'b0, rdy);
        for (int i = 0; i < dd; i++) cnt += int'(mv[k][i]);
        if (k == 0) begin
            check("rdy3", 64'(ir3), 64'(rdy));
            check("ov3",  64'(ov3), 64'(mv[0][2]));
            check("od3",  64'(od3), 64'(md[0][2]));
            check("occ3", 64'(oc3), 64'(cnt));
        end else begin
            check("rdy4", 64'(ir4), 64'(rdy));
            check("ov4",  64'(ov4), 64'(mv[1][3]));
            check("od4",  64'(od4), 64'(md[1][3]));
            check("occ4", 64'(oc4), 64'(cnt));
        end
    endtask

    // Called at the falling edge; returns at the next falling edge.
    task automatic cycle(input bit iv, input logic [38:0] id, input bit ordy,
                         input bit fl, output bit acc3);
        bit r;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_model(0);
        check_model(1);
        acc3 = iv & ir3 & rst;
        if (ov3 && ordy && rst) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) check("sb_order", 64'(od3), 64'(sb.pop_front()));
        end
        if (fl) sb.delete();
        else if (acc3) sb.push_back(id);
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            sweep(0, 1'b1, r);
            sweep(1, 1'b1, r);
        end
        @(negedge clk);
    endtask

    initial begin
        bit          a;
        int          wi;
        logic [38:0] wa, wb, wx;

        rst = 1'b0; in_valid = 1'b1; in_data = rnd(); out_ready = 1'b1; flush = 1'b0;
        model_reset();
        #2;
        check("rst_ov3", 64'(ov3), 64'(0));
        check("rst_od3", 64'(od3), 64'(0));
        check("rst_oc3", 64'(oc3), 64'(0));
        check("rst_ir3", 64'(ir3), 64'(1));
        @(negedge clk);
        repeat (3) cycle(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)), 1'b0, a);
        check("rst_ov4", 64'(ov4), 64'(0));
        check("rst_oc4", 64'(oc4), 64'(0));
        rst = 1'b1;

        // streaming at full rate
        for (int w = 1; w <= 5; w++) cycle(1'b1, 39'(w), 1'b1, 1'b0, a);
        check("t2_ov3", 64'(ov3), 64'(1));
        check("t2_od3", 64'(od3), 64'(3));
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b0, a);

        // stall then release
        wi = 0;
        for (int c = 0; c < 30 && wi < 5; c++) begin
            cycle(1'b1, 39'(32'h11 + wi), c >= 5, 1'b0, a);
            if (a) wi++;
            if (c == 4) begin
                check("t3_occ3", 64'(oc3), 64'(3));
                check("t3_ir3",  64'(ir3), 64'(0));
                check("t3_acc",  64'(wi),  64'(3));
            end
        end
        check("t3_all_acc", 64'(wi), 64'(5));
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b0, a);
        check("t3_drained", 64'(sb.size()), 64'(0));

        // bubble collapse
        wa = rnd(); wb = rnd();
        cycle(1'b1, wa, 1'b0, 1'b0, a);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, a);
        cycle(1'b1, wb, 1'b0, 1'b0, a);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, a);
        check("t4_occ4", 64'(oc4), 64'(2));
        check("t4_ov4",  64'(ov4), 64'(1));
        check("t4_od4",  64'(od4), 64'(wa));
        check("t4_ir4",  64'(ir4), 64'(1));
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b0, a);

        // flush with a full DEPTH-3 chain
        repeat (3) cycle(1'b1, rnd(), 1'b0, 1'b0, a);
        check("t5_occ3", 64'(oc3), 64'(3));
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        #1;
        check("t5_ir3", 64'(ir3), 64'(0));
        cycle(1'b1, rnd(), 1'b1, 1'b1, a);
        check("t5_occ3_after", 64'(oc3), 64'(0));
        check("t5_ov3_after",  64'(ov3), 64'(0));
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b0, a);

        // asynchronous reset mid-stream
        repeat (2) cycle(1'b1, rnd(), 1'b0, 1'b0, a);
        check("t6_occ3", 64'(oc3), 64'(2));
        #2 rst = 1'b0;
        #1;
        model_reset();
        sb.delete();
        check("t6_ov3", 64'(ov3), 64'(0));
        check("t6_od3", 64'(od3), 64'(0));
        check("t6_oc3", 64'(oc3), 64'(0));
        check("t6_oc4", 64'(oc4), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        wx = rnd();
        cycle(1'b1, wx, 1'b1, 1'b0, a);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, a);
        check("t6_ov3_lat", 64'(ov3), 64'(1));
        check("t6_od3_lat", 64'(od3), 64'(wx));

        // randomized traffic
        for (int c = 0; c < 400; c++)
            cycle($urandom_range(0, 9) < 7, rnd(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 39) == 0, a);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b0, a);
        check("final_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
